// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the data-memory port arbiter.
package mem_arb_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 9;

    typedef enum logic {
        IDLE,
        AUX_LOCK
    } arb_state_t;

    typedef enum logic [1:0] {
        NONE,
        CORE,
        AUX
    } owner_t;

endpackage

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing one data-memory port between the core load/store
// unit and an auxiliary master, with bounded aux locking and 1-cycle read return.
module dmem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int LOCK_MAX = 16
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] c_rdata,

    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    input  logic              a_lock,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,

    output logic              m_wr,
    output logic              m_rd,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,

    output logic              core_stall
);

    localparam int               CNT_W     = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] LOCK_LIMIT = CNT_W'(LOCK_MAX);

    arb_state_t        state_q, state_d;
    owner_t            last_win_q, last_win_d;
    owner_t            rd_owner_q, rd_owner_d;
    logic [CNT_W-1:0]  lock_cnt_q, lock_cnt_d;
    logic [DATA_W-1:0] c_rdata_q, c_rdata_d;
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d;

    // Grants are suppressed while reset is high so nothing reaches memory mid-reset.
    always_comb begin
        c_gnt = 1'b0;
        a_gnt = 1'b0;
        if (!reset) begin
            if (state_q == AUX_LOCK) begin
                if (c_req && (lock_cnt_q == LOCK_LIMIT)) begin
                    c_gnt = 1'b1;
                end else if (a_req) begin
                    a_gnt = 1'b1;
                end else if (c_req) begin
                    c_gnt = 1'b1;
                end
            end else begin
                if (c_req && a_req) begin
                    if (last_win_q == AUX) begin
                        c_gnt = 1'b1;
                    end else begin
                        a_gnt = 1'b1;
                    end
                end else begin
                    c_gnt = c_req;
                    a_gnt = a_req;
                end
            end
        end
    end

    always_comb begin
        m_wr    = (c_gnt & c_we) | (a_gnt & a_we);
        m_rd    = (c_gnt & ~c_we) | (a_gnt & ~a_we);
        m_addr  = '0;
        m_wdata = '0;
        if (c_gnt) begin
            m_addr  = c_addr;
            m_wdata = c_wdata;
        end else if (a_gnt) begin
            m_addr  = a_addr;
            m_wdata = a_wdata;
        end
        core_stall = c_req & ~c_gnt;
    end

    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        last_win_d = last_win_q;
        rd_owner_d = NONE;

        case (state_q)
            IDLE: begin
                if (a_gnt && a_lock) begin
                    state_d = AUX_LOCK;
                end
            end
            AUX_LOCK: begin
                if (!a_lock || (!a_req && !c_gnt)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A forced core grant resets the starvation window but keeps the lock.
        if (c_gnt || (state_d == IDLE)) begin
            lock_cnt_d = '0;
        end else if ((state_q == AUX_LOCK) && a_gnt && (lock_cnt_q != LOCK_LIMIT)) begin
            lock_cnt_d = lock_cnt_q + CNT_W'(1);
        end

        if (c_gnt) begin
            last_win_d = CORE;
        end else if (a_gnt) begin
            last_win_d = AUX;
        end

        if (c_gnt && !c_we) begin
            rd_owner_d = CORE;
        end else if (a_gnt && !a_we) begin
            rd_owner_d = AUX;
        end
    end

    // Memory data arrives the cycle after the strobe; pass it straight through
    // on the return cycle and hold it afterwards.
    always_comb begin
        c_rvalid  = (rd_owner_q == CORE);
        a_rvalid  = (rd_owner_q == AUX);
        c_rdata_d = c_rvalid ? m_rdata : c_rdata_q;
        a_rdata_d = a_rvalid ? m_rdata : a_rdata_q;
        c_rdata   = c_rdata_d;
        a_rdata   = a_rdata_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            last_win_q <= AUX;
            lock_cnt_q <= '0;
            rd_owner_q <= NONE;
            c_rdata_q  <= '0;
            a_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            last_win_q <= last_win_d;
            lock_cnt_q <= lock_cnt_d;
            rd_owner_q <= rd_owner_d;
            c_rdata_q  <= c_rdata_d;
            a_rdata_q  <= a_rdata_d;
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a simple single-port memory model.
module tb_dmem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        c_req, c_we, c_gnt, c_rvalid;
    logic [8:0]  c_addr;
    logic [31:0] c_wdata, c_rdata;
    logic        a_req, a_we, a_lock, a_gnt, a_rvalid;
    logic [8:0]  a_addr;
    logic [31:0] a_wdata, a_rdata;
    logic        m_wr, m_rd, core_stall;
    logic [8:0]  m_addr;
    logic [31:0] m_wdata, m_rdata;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [512];

    dmem_port_arbiter dut (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_lock(a_lock), .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .m_wr(m_wr), .m_rd(m_rd), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .core_stall(core_stall)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input logic [8:0] a);
        pat = (a == 9'h010) ? 32'hDEADBEEF : (32'hA500_0000 | {23'd0, a});
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 512; k++) mem[k] <= pat(9'(k));
        end else if (m_wr) begin
            mem[m_addr] <= m_wdata;
        end
        if (m_rd) m_rdata <= mem[m_addr];
    end

    typedef struct {
        logic        cr, cw;
        logic [8:0]  ca;
        logic [31:0] cd;
        logic        ar, aw, al;
        logic [8:0]  aa;
        logic [31:0] ad;
        logic        e_cg, e_ag, e_wr, e_rd;
        logic [8:0]  e_addr;
        logic [31:0] e_wd;
        logic        e_crv;
        logic [31:0] e_crd;
        logic        e_arv;
        logic [31:0] e_ard;
        logic        e_stall;
    } vec_t;

    vec_t vecs [16];

    function automatic vec_t mk(
        input logic cr, input logic cw, input logic [8:0] ca, input logic [31:0] cd,
        input logic ar, input logic aw, input logic al, input logic [8:0] aa, input logic [31:0] ad,
        input logic e_cg, input logic e_ag, input logic e_wr, input logic e_rd,
        input logic [8:0] e_addr, input logic [31:0] e_wd,
        input logic e_crv, input logic [31:0] e_crd,
        input logic e_arv, input logic [31:0] e_ard, input logic e_stall);
        vec_t v;
        v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
        v.ar = ar; v.aw = aw; v.al = al; v.aa = aa; v.ad = ad;
        v.e_cg = e_cg; v.e_ag = e_ag; v.e_wr = e_wr; v.e_rd = e_rd;
        v.e_addr = e_addr; v.e_wd = e_wd;
        v.e_crv = e_crv; v.e_crd = e_crd; v.e_arv = e_arv; v.e_ard = e_ard;
        v.e_stall = e_stall;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic cr, input logic cw, input logic [8:0] ca, input logic [31:0] cd,
                         input logic ar, input logic aw, input logic al, input logic [8:0] aa,
                         input logic [31:0] ad);
        c_req = cr; c_we = cw; c_addr = ca; c_wdata = cd;
        a_req = ar; a_we = aw; a_lock = al; a_addr = aa; a_wdata = ad;
    endtask

    initial begin
        // Both-read ping-pong after reset, then core read, aux write, core write, aux read.
        vecs[0]  = mk(1'b1,1'b0,9'h020,32'h0, 1'b1,1'b0,1'b0,9'h031,32'h0, 1'b1,1'b0,1'b0,1'b1,9'h020,32'h0, 1'b0,32'h0,        1'b0,32'h0,        1'b0);
        vecs[1]  = mk(1'b1,1'b0,9'h021,32'h0, 1'b1,1'b0,1'b0,9'h031,32'h0, 1'b0,1'b1,1'b0,1'b1,9'h031,32'h0, 1'b1,32'hA5000020, 1'b0,32'h0,        1'b1);
        vecs[2]  = mk(1'b1,1'b0,9'h021,32'h0, 1'b1,1'b0,1'b0,9'h032,32'h0, 1'b1,1'b0,1'b0,1'b1,9'h021,32'h0, 1'b0,32'hA5000020, 1'b1,32'hA5000031, 1'b0);
        vecs[3]  = mk(1'b1,1'b0,9'h022,32'h0, 1'b1,1'b0,1'b0,9'h032,32'h0, 1'b0,1'b1,1'b0,1'b1,9'h032,32'h0, 1'b1,32'hA5000021, 1'b0,32'hA5000031, 1'b1);
        vecs[4]  = mk(1'b0,1'b0,9'h000,32'h0, 1'b0,1'b0,1'b0,9'h000,32'h0, 1'b0,1'b0,1'b0,1'b0,9'h000,32'h0, 1'b0,32'hA5000021, 1'b1,32'hA5000032, 1'b0);
        vecs[5]  = mk(1'b1,1'b0,9'h010,32'h0, 1'b0,1'b0,1'b0,9'h000,32'h0, 1'b1,1'b0,1'b0,1'b1,9'h010,32'h0, 1'b0,32'hA5000021, 1'b0,32'hA5000032, 1'b0);
        vecs[6]  = mk(1'b0,1'b0,9'h000,32'h0, 1'b0,1'b0,1'b0,9'h000,32'h0, 1'b0,1'b0,1'b0,1'b0,9'h000,32'h0, 1'b1,32'hDEADBEEF, 1'b0,32'hA5000032, 1'b0);
        vecs[7]  = mk(1'b0,1'b0,9'h000,32'h0, 1'b1,1'b1,1'b0,9'h1FF,32'h12345678, 1'b0,1'b1,1'b1,1'b0,9'h1FF,32'h12345678, 1'b0,32'hDEADBEEF, 1'b0,32'hA5000032, 1'b0);
        vecs[8]  = mk(1'b1,1'b0,9'h1FF,32'h0, 1'b0,1'b0,1'b0,9'h000,32'h0, 1'b1,1'b0,1'b0,1'b1,9'h1FF,32'h0, 1'b0,32'hDEADBEEF, 1'b0,32'hA5000032, 1'b0);
        vecs[9]  = mk(1'b0,1'b0,9'h000,32'h0, 1'b0,1'b0,1'b0,9'h000,32'h0, 1'b0,1'b0,1'b0,1'b0,9'h000,32'h0, 1'b1,32'h12345678, 1'b0,32'hA5000032, 1'b0);
        vecs[10] = mk(1'b1,1'b1,9'h005,32'hCAFEF00D, 1'b0,1'b0,1'b0,9'h000,32'h0, 1'b1,1'b0,1'b1,1'b0,9'h005,32'hCAFEF00D, 1'b0,32'h12345678, 1'b0,32'hA5000032, 1'b0);
        vecs[11] = mk(1'b0,1'b0,9'h000,32'h0, 1'b0,1'b0,1'b0,9'h000,32'h0, 1'b0,1'b0,1'b0,1'b0,9'h000,32'h0, 1'b0,32'h12345678, 1'b0,32'hA5000032, 1'b0);
        vecs[12] = mk(1'b0,1'b0,9'h000,32'h0, 1'b1,1'b0,1'b0,9'h005,32'h0, 1'b0,1'b1,1'b0,1'b1,9'h005,32'h0, 1'b0,32'h12345678, 1'b0,32'hA5000032, 1'b0);
        vecs[13] = mk(1'b0,1'b0,9'h000,32'h0, 1'b0,1'b0,1'b0,9'h000,32'h0, 1'b0,1'b0,1'b0,1'b0,9'h000,32'h0, 1'b0,32'h12345678, 1'b1,32'hCAFEF00D, 1'b0);
        vecs[14] = mk(1'b0,1'b0,9'h000,32'h0, 1'b0,1'b0,1'b0,9'h000,32'h0, 1'b0,1'b0,1'b0,1'b0,9'h000,32'h0, 1'b0,32'h12345678, 1'b0,32'hCAFEF00D, 1'b0);
        vecs[15] = mk(1'b0,1'b1,9'h1AA,32'h55AA55AA, 1'b0,1'b1,1'b1,9'h0AA,32'hAA55AA55, 1'b0,1'b0,1'b0,1'b0,9'h000,32'h0, 1'b0,32'h12345678, 1'b0,32'hCAFEF00D, 1'b0);

        // Reset with both sides requesting: nothing may be granted or strobed.
        reset = 1'b1;
        drive(1'b1, 1'b0, 9'h010, 32'h0, 1'b1, 1'b1, 1'b1, 9'h011, 32'h1);
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_c_gnt",    32'(c_gnt),    32'd0);
        chk("rst_a_gnt",    32'(a_gnt),    32'd0);
        chk("rst_m_wr",     32'(m_wr),     32'd0);
        chk("rst_m_rd",     32'(m_rd),     32'd0);
        chk("rst_c_rvalid", 32'(c_rvalid), 32'd0);
        chk("rst_a_rvalid", 32'(a_rvalid), 32'd0);
        chk("rst_c_rdata",  c_rdata,       32'd0);
        chk("rst_a_rdata",  a_rdata,       32'd0);
        @(negedge clk);
        drive(1'b0, 1'b0, 9'h0, 32'h0, 1'b0, 1'b0, 1'b0, 9'h0, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive(vecs[i].cr, vecs[i].cw, vecs[i].ca, vecs[i].cd,
                  vecs[i].ar, vecs[i].aw, vecs[i].al, vecs[i].aa, vecs[i].ad);
            #1;
            chk($sformatf("v%0d_c_gnt", i),    32'(c_gnt),      32'(vecs[i].e_cg));
            chk($sformatf("v%0d_a_gnt", i),    32'(a_gnt),      32'(vecs[i].e_ag));
            chk($sformatf("v%0d_m_wr", i),     32'(m_wr),       32'(vecs[i].e_wr));
            chk($sformatf("v%0d_m_rd", i),     32'(m_rd),       32'(vecs[i].e_rd));
            chk($sformatf("v%0d_m_addr", i),   32'(m_addr),     32'(vecs[i].e_addr));
            chk($sformatf("v%0d_m_wdata", i),  m_wdata,         vecs[i].e_wd);
            chk($sformatf("v%0d_c_rvalid", i), 32'(c_rvalid),   32'(vecs[i].e_crv));
            chk($sformatf("v%0d_c_rdata", i),  c_rdata,         vecs[i].e_crd);
            chk($sformatf("v%0d_a_rvalid", i), 32'(a_rvalid),   32'(vecs[i].e_arv));
            chk($sformatf("v%0d_a_rdata", i),  a_rdata,         vecs[i].e_ard);
            chk($sformatf("v%0d_stall", i),    32'(core_stall), 32'(vecs[i].e_stall));
        end

        // Locked aux burst against a waiting core: first tie goes to the core,
        // aux then wins IDLE plus 16 locked grants, later windows are 16 grants.
        @(negedge clk);
        reset = 1'b1;
        drive(1'b0, 1'b0, 9'h0, 32'h0, 1'b0, 1'b0, 1'b0, 9'h0, 32'h0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        begin
            logic prev_c;
            prev_c = 1'b0;
            for (int i = 0; i < 40; i++) begin
                logic exp_c;
                @(negedge clk);
                drive(1'b1, 1'b0, 9'h040, 32'h0, 1'b1, 1'b0, 1'b1, 9'h050, 32'h0);
                #1;
                exp_c = (i == 0) || (i == 18) || (i == 35);
                chk($sformatf("burst%0d_c_gnt", i), 32'(c_gnt), 32'(exp_c));
                chk($sformatf("burst%0d_a_gnt", i), 32'(a_gnt), 32'(!exp_c));
                chk($sformatf("burst%0d_stall", i), 32'(core_stall), 32'(!exp_c));
                if (i > 0) begin
                    chk($sformatf("burst%0d_c_rvalid", i), 32'(c_rvalid), 32'(prev_c));
                    chk($sformatf("burst%0d_a_rvalid", i), 32'(a_rvalid), 32'(!prev_c));
                end
                if (i == 1) chk("burst_c_rdata", c_rdata, 32'hA5000040);
                if (i == 2) chk("burst_a_rdata", a_rdata, 32'hA5000050);
                prev_c = exp_c;
            end
        end

        // Lock dropped mid-burst: aux still wins this cycle, then IDLE round-robin.
        @(negedge clk);
        drive(1'b1, 1'b0, 9'h041, 32'h0, 1'b1, 1'b0, 1'b0, 9'h051, 32'h0);
        #1;
        chk("drop0_a_gnt", 32'(a_gnt), 32'd1);
        @(negedge clk); #1;
        chk("drop1_c_gnt", 32'(c_gnt), 32'd1);
        chk("drop1_a_gnt", 32'(a_gnt), 32'd0);
        @(negedge clk); #1;
        chk("drop2_a_gnt", 32'(a_gnt), 32'd1);
        @(negedge clk); #1;
        chk("drop3_c_gnt", 32'(c_gnt), 32'd1);

        // Asynchronous reset between an aux read grant and its return.
        @(negedge clk);
        drive(1'b0, 1'b0, 9'h0, 32'h0, 1'b1, 1'b0, 1'b0, 9'h060, 32'h0);
        #1;
        chk("rmid_a_gnt", 32'(a_gnt), 32'd1);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("rmid_a_rvalid", 32'(a_rvalid), 32'd0);
        chk("rmid_a_rdata",  a_rdata,       32'd0);
        chk("rmid_c_rdata",  c_rdata,       32'd0);
        chk("rmid_a_gnt2",   32'(a_gnt),    32'd0);
        chk("rmid_c_gnt",    32'(c_gnt),    32'd0);
        chk("rmid_m_rd",     32'(m_rd),     32'd0);
        chk("rmid_m_wr",     32'(m_wr),     32'd0);
        chk("rmid_m_addr",   32'(m_addr),   32'd0);
        chk("rmid_stall",    32'(core_stall), 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b1, 1'b0, 9'h070, 32'h0, 1'b1, 1'b0, 1'b0, 9'h071, 32'h0);
        #1;
        chk("post_c_gnt",    32'(c_gnt),    32'd1);
        chk("post_a_gnt",    32'(a_gnt),    32'd0);
        chk("post_a_rvalid", 32'(a_rvalid), 32'd0);
        @(negedge clk);
        drive(1'b0, 1'b0, 9'h0, 32'h0, 1'b0, 1'b0, 1'b0, 9'h0, 32'h0);
        #1;
        chk("post_c_rvalid", 32'(c_rvalid), 32'd1);
        chk("post_c_rdata",  c_rdata,       32'hA5000070);
        chk("post_a_rv2",    32'(a_rvalid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
